eth_port_tx: RTL
================

# eth_port_tx

Egress-side frame reader for the Ethernet switch. It drains one `eth_fifo` instance through that FIFO's read port and presents length-prefixed frames on a byte-wide transmit port. The transmit port has start/end markers, valid/ready backpressure and a programmable inter-frame gap. It sits between the egress FIFO of each switch port and the port's line interface, and is the counterpart of the ingress logic that writes frames into the FIFO.

## Interface
- `DATA_W`, 8: byte width; must equal the FIFO's `FIFO_W`. The length header is also `DATA_W` bits.
- `IFG`, 12: idle cycles forced after each frame's last byte is accepted. 0 allows back-to-back frames.
- `clk` input 1: single clock for all logic.
- `reset` input 1: synchronous, active-high reset.
- `fifo_empty` input 1: FIFO `empty` flag.
- `fifo_rd_en` output 1: FIFO `read_en`; one byte is requested per high cycle.
- `fifo_data` input DATA_W: FIFO `data_out`; valid the cycle after `fifo_rd_en`.
- `tx_data` output DATA_W: transmit byte.
- `tx_valid` output 1: `tx_data` and markers are valid.
- `tx_sof` output 1: first payload byte of the frame; qualified by `tx_valid`.
- `tx_eof` output 1: last payload byte of the frame; qualified by `tx_valid`.
- `tx_ready` input 1: sink accepts the byte when `tx_valid && tx_ready`.
- `busy` output 1: the state machine is not in IDLE.
- `tx_frame_cnt` output 16: count of frames sent. Present only with `ETH_TX_FRAME_CNT_EN`.

## Operation
- **FIFO frame format:**
  - Header byte L, then L payload bytes.
  - L=0 is a null header: it is consumed and no output is produced.
- **Read side:**
  - Internal 2-entry byte buffer plus one outstanding-read flag `pend`.
  - `fifo_rd_en = !reset && !fifo_empty && (occ - pop + pend) < 2`, where `pop` means a buffer byte is consumed this cycle.
  - A byte returned on `fifo_data` is written into the buffer at the end of the cycle after the read.
  - The buffer never overflows.
- **State machine: IDLE, DATA, GAP.**
  - IDLE: when the buffer is non-empty, pop the header into the remaining-byte counter `rem`.
    - If L≠0, go to DATA with `first`=1.
    - If L=0, stay in IDLE.
  - DATA:
    - `tx_valid` = buffer non-empty.
    - `tx_data` = buffer head.
    - `tx_sof` = `first`.
    - `tx_eof` = (`rem`==1).
    - On transfer: pop the buffer, `rem`−1, `first`←0.
    - On transfer with `tx_eof`: go to GAP with gap counter = IFG, or go straight to IDLE if IFG=0.
  - GAP: decrement the gap counter each cycle and go to IDLE when it reaches 1.
    - Reads continue during GAP, prefetching the next header.
- **FIFO underrun mid-frame:** `tx_valid` drops and the frame resumes when data arrives. The frame is never terminated early.
- **Output hold:** while `tx_valid && !tx_ready`, `tx_data`, `tx_sof` and `tx_eof` hold stable.
- **Arithmetic:** `rem` is DATA_W bits and the gap counter is $clog2(IFG+1) bits, minimum 1.

## Timing
- **Reset values:**
  - `fifo_rd_en`=0, `tx_valid`=0, `tx_sof`=0, `tx_eof`=0, `tx_data`=0, `busy`=0, `tx_frame_cnt`=0.
  - Buffer empty, `pend`=0, state IDLE.
- **Reset mid-frame:**
  - Abandons the frame; no `tx_eof` is produced.
  - A FIFO byte returning in the cycle after reset is discarded.
  - The FIFO is reset in the same cycle by the parent.
- **Latency:** header read in cycle t0 (FIFO non-empty) → first `tx_valid`/`tx_sof` in cycle t0+3.
- **Throughput:** one byte per cycle when `tx_ready`=1 and the FIFO stays non-empty.
- **Frame to frame:**
  - The last byte is accepted in cycle t.
  - The next frame's `tx_sof` comes no earlier than t+IFG+2.
  - With IFG=0 this is t+2, because one IDLE cycle pops the next header.
- **Simultaneous events:** a buffer pop and a FIFO return in the same cycle are both honoured. Occupancy is unchanged.

## Configuration
- **`ETH_TX_FRAME_CNT_EN` defined:**
  - `tx_frame_cnt` port exists.
  - It increments by 1 on each accepted `tx_eof` byte and wraps from 16'hFFFF to 0.
  - Null headers do not count.
- **Not defined:** the port and counter are absent; all other behaviour is identical.

## Test plan
- **Single frame:** FIFO holds 03,A1,A2,A3; `tx_ready`=1; IFG=12.
  - Expect A1(sof), A2, A3(eof) on consecutive cycles, first byte 3 cycles after the first `fifo_rd_en`.
  - Then `tx_valid`=0 for at least 12 cycles.
- **Back-to-back frames:** IFG=2; FIFO holds 02,11,22,01,33.
  - Expect 11(sof), 22(eof), then a gap, then 33 with sof and eof both high.
  - The 33 byte comes exactly 4 cycles after 22 is accepted.
- **Backpressure:** `tx_ready`=0 for 5 cycles on byte 2 of 04,B0,B1,B2,B3.
  - B1 holds stable.
  - `fifo_rd_en` stops after the buffer fills (at most 2 buffered bytes plus 1 pending).
  - No byte is lost or duplicated.
- **Null header and underrun:** FIFO holds 00,02,C0, then empty for 6 cycles, then C1.
  - No output for the null header.
  - C0(sof) appears, then `tx_valid`=0 for the gap, then C1(eof).
- **Reset mid-frame:** reset is asserted one cycle after the sof of a 10-byte frame.
  - All outputs read 0 the next cycle.
  - After release, a fresh frame 01,DD in the FIFO yields DD with sof and eof.
- **Frame counter** (`ETH_TX_FRAME_CNT_EN`): preload via 65535 short frames, or force the counter to FFFF.
  - One more frame gives `tx_frame_cnt`=0.

Source files
------------

// File: rtl/eth_port_tx.sv
// eth_port_tx: egress frame reader. Drains length-prefixed frames (header
// byte L followed by L payload bytes) from an eth_fifo read port and presents
// them on a byte-wide valid/ready transmit port with sof/eof markers and a
// programmable inter-frame gap.
//
// Optional feature macro: ETH_TX_FRAME_CNT_EN adds the tx_frame_cnt output,
// a wrapping 16-bit count of frames whose last byte was accepted.
//
// Read side: a 2-entry byte buffer plus one outstanding-read flag. A read is
// issued only when the buffer is guaranteed to have room for the returning
// byte, so the buffer never overflows and the FIFO latency (data valid the
// cycle after read_en) is hidden behind the buffer.

module eth_port_tx #(
    parameter int DATA_W = 8,
    parameter int IFG    = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_data,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    output logic              tx_sof,
    output logic              tx_eof,
    input  logic              tx_ready,
    output logic              busy
`ifdef ETH_TX_FRAME_CNT_EN
    ,
    output logic [15:0]       tx_frame_cnt
`endif
);

    // Gap counter must hold IFG; keep at least one bit when IFG is 0.
    localparam int GAP_W  = (IFG > 0) ? $clog2(IFG + 1) : 1;
    localparam bit GAP_EN = (IFG != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Byte buffer and read-request bookkeeping
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_buf [0:1];
    logic              r_head;
    logic              r_tail;
    logic [1:0]        r_occ;
    logic              r_pend;

    logic              w_pop;
    logic              w_push;
    logic              w_buf_nonempty;
    logic [DATA_W-1:0] w_head_byte;
    logic [2:0]        w_occ_after;

    assign w_push         = r_pend;
    assign w_buf_nonempty = (r_occ != 2'd0);
    assign w_head_byte    = r_buf[r_head];

    // Occupancy the buffer will have once this cycle's pop is applied and the
    // read already in flight lands; a new read is only safe below 2.
    assign w_occ_after = {1'b0, r_occ} + {2'b00, r_pend} - {2'b00, w_pop};
    assign fifo_rd_en  = !reset && !fifo_empty && (w_occ_after < 3'd2);

    // Buffer pointers, occupancy and pending-read flag; a byte returning in
    // the cycle reset is sampled is dropped because reset wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head <= 1'b0;
            r_tail <= 1'b0;
            r_occ  <= 2'd0;
            r_pend <= 1'b0;
        end else begin
            r_pend <= fifo_rd_en;
            if (w_push) begin
                r_tail <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Buffer storage: returning FIFO byte lands at the tail slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf[0] <= '0;
            r_buf[1] <= '0;
        end else if (w_push) begin
            r_buf[r_tail] <= fifo_data;
        end
    end

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    state_t            r_state;
    state_t            w_state_next;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] w_rem_next;
    logic              r_first;
    logic              w_first_next;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [GAP_W-1:0]  w_gap_next;
    logic              w_xfer;

    // State register together with the per-frame counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_rem     <= '0;
            r_first   <= 1'b0;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_rem     <= w_rem_next;
            r_first   <= w_first_next;
            r_gap_cnt <= w_gap_next;
        end
    end

    // Next-state logic and transmit outputs; outputs are forced to zero
    // whenever no byte is being presented so idle cycles are clean.
    always_comb begin
        w_state_next = r_state;
        w_rem_next   = r_rem;
        w_first_next = r_first;
        w_gap_next   = r_gap_cnt;
        w_pop        = 1'b0;
        w_xfer       = 1'b0;
        tx_valid     = 1'b0;
        tx_data      = '0;
        tx_sof       = 1'b0;
        tx_eof       = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Header byte: a zero length is swallowed and we keep looking.
                if (w_buf_nonempty) begin
                    w_pop      = 1'b1;
                    w_rem_next = w_head_byte;
                    if (w_head_byte != '0) begin
                        w_state_next = S_DATA;
                        w_first_next = 1'b1;
                    end
                end
            end

            S_DATA: begin
                // An empty buffer mid-frame just stalls; the frame is never cut.
                if (w_buf_nonempty) begin
                    tx_valid = 1'b1;
                    tx_data  = w_head_byte;
                    tx_sof   = r_first;
                    tx_eof   = (r_rem == DATA_W'(1));
                end
                w_xfer = w_buf_nonempty && tx_ready;
                if (w_xfer) begin
                    w_pop        = 1'b1;
                    w_rem_next   = r_rem - DATA_W'(1);
                    w_first_next = 1'b0;
                    if (r_rem == DATA_W'(1)) begin
                        if (GAP_EN) begin
                            w_state_next = S_GAP;
                            w_gap_next   = GAP_W'(IFG);
                        end else begin
                            w_state_next = S_IDLE;
                        end
                    end
                end
            end

            S_GAP: begin
                // Reads keep running here so the next header is prefetched.
                w_gap_next = r_gap_cnt - GAP_W'(1);
                if (r_gap_cnt <= GAP_W'(1)) begin
                    w_state_next = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign busy = (r_state != S_IDLE);

`ifdef ETH_TX_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    // Count frames whose last byte was accepted; wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_cnt <= 16'd0;
        end else if (w_xfer && tx_eof) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign tx_frame_cnt = r_frame_cnt;
`endif

endmodule
